// File: rtl/pixel_pkg.sv
// pixel_pkg: shared image geometry, coordinate type and cache state encoding.
package pixel_pkg;
   localparam int IMG_W = 640;
   localparam int IMG_H = 480;
   localparam int BYTES_PER_ROW = IMG_W / 8;
   typedef logic [9:0] coord_t;
   typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: maps a pixel coordinate to its packed byte address, bit index and range flag.
module pixel_addr_gen #(
   parameter int IMG_W = pixel_pkg::IMG_W,
   parameter int IMG_H = pixel_pkg::IMG_H,
   parameter int ADDR_W = 16
) (
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic [2:0]        bit_sel,
   output logic              in_range
);
   localparam logic [ADDR_W-1:0] BPR = ADDR_W'(IMG_W / 8);
   logic [ADDR_W-1:0] row;
   // y * bytes-per-row as a constant shift-add at full address width
   always_comb begin
      row = '0;
      for (int i = 0; i < ADDR_W; i++)
         if (BPR[i]) row = row + (ADDR_W'(y) << i);
   end
   assign addr = row + ADDR_W'(x[9:3]);
   assign bit_sel = x[2:0];
   assign in_range = (32'(x) < IMG_W) && (32'(y) < IMG_H);
endmodule

// File: rtl/pixel_cache.sv
// pixel_cache: single-byte read cache over the packed binary image memory.
// Define PIXEL_CACHE_STATS_EN to add saturating hit/miss counters with stats_clear.
module pixel_cache #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int ADDR_W = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic              pixel,
   output logic              ready,
   input  logic              invalidate,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [7:0]        rdata
`ifdef PIXEL_CACHE_STATS_EN
   ,
   input  logic              stats_clear,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   import pixel_pkg::*;
   localparam int CW = $clog2(RD_LATENCY) + 1;
   state_t state;
   logic valid, killed, in_range, hit, miss;
   logic [ADDR_W-1:0] tag, pend, addr;
   logic [7:0] line;
   logic [CW-1:0] cnt;
   logic [2:0] bit_sel;
   pixel_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr (
      .x(x), .y(y), .addr(addr), .bit_sel(bit_sel), .in_range(in_range)
   );
   assign hit = valid && tag == addr;
   assign miss = in_range && !hit;
   assign ready = !in_range || hit;
   assign pixel = in_range && hit && line[bit_sel];
   always_ff @(posedge clk)
      if (!reset_n) begin
         state <= IDLE;
         valid <= 1'b0;
         killed <= 1'b0;
         tag <= '0;
         pend <= '0;
         line <= '0;
         cnt <= '0;
         rdaddress <= '0;
      end else begin
         case (state)
            IDLE:
               if (miss) begin
                  rdaddress <= addr;
                  pend <= addr;
                  cnt <= CW'(RD_LATENCY - 1);
                  state <= WAIT;
               end
            WAIT:
               if (cnt == '0) begin
                  line <= rdata;
                  tag <= pend;
                  valid <= !killed;
                  killed <= 1'b0;
                  state <= IDLE;
               end else
                  cnt <= cnt - 1'b1;
         endcase
         // an invalidate mid-fetch must also poison the fill that lands later
         if (invalidate) begin
            valid <= 1'b0;
            if (state == WAIT && cnt != '0) killed <= 1'b1;
         end
      end
`ifdef PIXEL_CACHE_STATS_EN
   always_ff @(posedge clk)
      if (!reset_n || stats_clear) begin
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         if (in_range && hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
         if (state == IDLE && miss && !(&miss_count)) miss_count <= miss_count + 1'b1;
      end
`endif
endmodule
